// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared definitions for the decoder scan sequencer: slot geometry, FSM encoding,
// and the dwell/blank counter sizing helper.
package decoder_scan_ctrl_pkg;

  localparam int SLOT_W    = 2;
  localparam int NUM_SLOTS = 1 << SLOT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  // Counter only ever holds DIV-1 or BLANK-1, so log2 of the larger bound suffices.
  function automatic int cnt_width(input int div, input int blank);
    int m;
    m = (div > blank) ? div : blank;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/decoder_scan_ctrl_slot_picker.sv
// Circular priority search over the line mask: returns the first enabled slot
// at (incl=1) or strictly after (incl=0) the current index, wrapping around.
module slot_picker
  import decoder_scan_ctrl_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] mask,
  input  logic [SLOT_W-1:0]    cur,
  input  logic                 incl,
  output logic [SLOT_W-1:0]    next,
  output logic                 valid
);

  logic [SLOT_W-1:0] base;
  logic [SLOT_W-1:0] cand;

  // Scan farthest-first so the nearest enabled slot is the last write and wins.
  always_comb begin
    base = incl ? cur : cur + SLOT_W'(1);
    cand = '0;
    next = cur;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      cand = base + SLOT_W'(k);
      if (mask[cand]) next = cand;
    end
    valid = |mask;
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Round-robin scan sequencer for a 2-to-4 decoder: drives select {A,B} and the
// active-low enable with a programmable dwell per slot and optional blanking gap.
module decoder_scan_ctrl
  import decoder_scan_ctrl_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int BLANK = 1
) (
  input  logic                 clock,
  input  logic                 reset_b,
  input  logic                 run,
  input  logic [NUM_SLOTS-1:0] mask,
  output logic                 A,
  output logic                 B,
  output logic                 enable,
  output logic                 slot_done,
  output logic                 busy
);

  localparam int CW         = cnt_width(DIV, BLANK);
  localparam int BLANK_M1_I = (BLANK > 0) ? BLANK - 1 : 0;
  localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_M1 = CW'(BLANK_M1_I);

  state_t            state, state_n;
  logic [SLOT_W-1:0] idx, idx_n;
  logic [SLOT_W-1:0] sel, sel_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              en_n, done_n, busy_n;

  logic [SLOT_W-1:0] pick;
  logic              pick_vld;
  logic              pick_incl;

  slot_picker u_pick (
    .mask  (mask),
    .cur   (idx),
    .incl  (pick_incl),
    .next  (pick),
    .valid (pick_vld)
  );

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state     <= ST_IDLE;
      idx       <= '0;
      sel       <= '0;
      cnt       <= '0;
      enable    <= 1'b1;
      slot_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      sel       <= sel_n;
      cnt       <= cnt_n;
      enable    <= en_n;
      slot_done <= done_n;
      busy      <= busy_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    sel_n     = sel;
    cnt_n     = cnt;
    en_n      = enable;
    pick_incl = (state == ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (run && pick_vld) begin
          sel_n   = pick;
          idx_n   = pick;
          en_n    = 1'b0;
          cnt_n   = DIV_M1;
          state_n = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (!run || !pick_vld) begin
          // Park on the following slot so a later restart continues the rotation.
          en_n    = 1'b1;
          state_n = ST_IDLE;
          if (pick_vld) idx_n = pick;
        end else if (BLANK == 0) begin
          sel_n = pick;
          idx_n = pick;
          cnt_n = DIV_M1;
        end else begin
          en_n    = 1'b1;
          sel_n   = pick;
          idx_n   = pick;
          cnt_n   = BLANK_M1;
          state_n = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (run && pick_vld) begin
          en_n    = 1'b0;
          cnt_n   = DIV_M1;
          state_n = ST_DRIVE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        en_n    = 1'b1;
      end
    endcase
    // Registered pulse lands in the cycle where the dwell counter reads zero.
    done_n = (state_n == ST_DRIVE) && (cnt_n == '0);
    busy_n = (state_n != ST_IDLE);
  end

  assign A = sel[1];
  assign B = sel[0];

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl using three instances with different
// DIV/BLANK settings sharing one clock and reset.
module tb_decoder_scan_ctrl;

  logic       clock = 1'b0;
  logic       reset_b;
  logic       run0, run1, run2;
  logic [3:0] mask0, mask1, mask2;
  logic       a0, b0, en0, done0, busy0;
  logic       a1, b1, en1, done1, busy1;
  logic       a2, b2, en2, done2, busy2;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  decoder_scan_ctrl #(.DIV(4), .BLANK(1)) u0 (
    .clock(clock), .reset_b(reset_b), .run(run0), .mask(mask0),
    .A(a0), .B(b0), .enable(en0), .slot_done(done0), .busy(busy0));

  decoder_scan_ctrl #(.DIV(2), .BLANK(0)) u1 (
    .clock(clock), .reset_b(reset_b), .run(run1), .mask(mask1),
    .A(a1), .B(b1), .enable(en1), .slot_done(done1), .busy(busy1));

  decoder_scan_ctrl #(.DIV(2), .BLANK(1)) u2 (
    .clock(clock), .reset_b(reset_b), .run(run2), .mask(mask2),
    .A(a2), .B(b2), .enable(en2), .slot_done(done2), .busy(busy2));

  task automatic do_reset;
    run0 = 0; run1 = 0; run2 = 0;
    reset_b = 0;
    repeat (2) @(negedge clock);
    reset_b = 1;
    @(negedge clock);
  endtask

  task automatic test_reset;
    logic [4:0] got;
    run0 = 0; run1 = 0; run2 = 0;
    mask0 = 4'hF; mask1 = 4'hF; mask2 = 4'hF;
    reset_b = 0;
    @(negedge clock);
    got = {a0, b0, en0, done0, busy0};
    checks++;
    if (got !== 5'b00100) begin errors++; $display("FAIL reset_u0: got %b exp 00100", got); end
    got = {a1, b1, en1, done1, busy1};
    checks++;
    if (got !== 5'b00100) begin errors++; $display("FAIL reset_u1: got %b exp 00100", got); end
    got = {a2, b2, en2, done2, busy2};
    checks++;
    if (got !== 5'b00100) begin errors++; $display("FAIL reset_u2: got %b exp 00100", got); end
    reset_b = 1;
    repeat (3) @(negedge clock);
    got = {a0, b0, en0, done0, busy0};
    checks++;
    if (got !== 5'b00100) begin errors++; $display("FAIL idle_no_run: got %b exp 00100", got); end
  endtask

  task automatic test_full_scan;
    logic [1:0] s, exp_sel;
    logic       exp_en, exp_done;
    int         p, pulses;
    do_reset();
    mask0 = 4'b1111;
    run0  = 1;
    pulses = 0;
    for (int t = 0; t <= 20; t++) begin
      @(negedge clock);
      s        = 2'((t / 5) % 4);
      p        = t % 5;
      exp_sel  = (p < 4) ? s : s + 2'd1;
      exp_en   = (p == 4);
      exp_done = (p == 3);
      if (t < 20 && done0) pulses++;
      checks++;
      if ({a0, b0, en0, done0, busy0} !== {exp_sel, exp_en, exp_done, 1'b1}) begin
        errors++;
        $display("FAIL full_scan t=%0d: got ab=%b%b en=%b done=%b busy=%b exp ab=%b en=%b done=%b busy=1",
                 t, a0, b0, en0, done0, busy0, exp_sel, exp_en, exp_done);
      end
    end
    checks++;
    if (pulses != 4) begin errors++; $display("FAIL full_scan_pulses: got %0d exp 4", pulses); end
    run0 = 0;
  endtask

  task automatic test_alt_mask;
    logic [1:0] exp_sel;
    do_reset();
    mask1 = 4'b1010;
    run1  = 1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clock);
      exp_sel = ((t / 2) % 2 == 1) ? 2'b11 : 2'b01;
      checks++;
      if ({a1, b1, en1, done1} !== {exp_sel, 1'b0, (t % 2 == 1)}) begin
        errors++;
        $display("FAIL alt_mask t=%0d: got ab=%b%b en=%b done=%b exp ab=%b en=0 done=%b",
                 t, a1, b1, en1, done1, exp_sel, (t % 2 == 1));
      end
    end
    run1 = 0;
  endtask

  task automatic test_single_line;
    logic exp_en;
    do_reset();
    mask2 = 4'b0100;
    run2  = 1;
    for (int t = 0; t < 9; t++) begin
      @(negedge clock);
      exp_en = (t % 3 == 2);
      checks++;
      if ({a2, b2, en2, done2} !== {2'b10, exp_en, (t % 3 == 1)}) begin
        errors++;
        $display("FAIL single_line t=%0d: got ab=%b%b en=%b done=%b exp ab=10 en=%b done=%b",
                 t, a2, b2, en2, done2, exp_en, (t % 3 == 1));
      end
    end
    run2 = 0;
  endtask

  task automatic test_run_drop;
    do_reset();
    mask0 = 4'b1111;
    run0  = 1;
    repeat (6) @(negedge clock);
    checks++;
    if ({a0, b0, en0} !== 3'b010) begin
      errors++; $display("FAIL drop_pre: got ab=%b%b en=%b exp ab=01 en=0", a0, b0, en0);
    end
    run0 = 0;
    for (int t = 6; t <= 8; t++) begin
      @(negedge clock);
      checks++;
      if ({a0, b0, en0, done0, busy0} !== {3'b010, (t == 8), 1'b1}) begin
        errors++;
        $display("FAIL drop_dwell t=%0d: got ab=%b%b en=%b done=%b busy=%b exp ab=01 en=0 done=%b busy=1",
                 t, a0, b0, en0, done0, busy0, (t == 8));
      end
    end
    @(negedge clock);
    checks++;
    if ({en0, busy0} !== 2'b10) begin
      errors++; $display("FAIL drop_idle: got en=%b busy=%b exp en=1 busy=0", en0, busy0);
    end
    @(negedge clock);
    checks++;
    if ({en0, busy0, done0} !== 3'b100) begin
      errors++; $display("FAIL drop_hold: got en=%b busy=%b done=%b exp 1 0 0", en0, busy0, done0);
    end
    run0 = 1;
    @(negedge clock);
    checks++;
    if ({a0, b0, en0, busy0} !== 4'b1001) begin
      errors++; $display("FAIL drop_resume: got ab=%b%b en=%b busy=%b exp ab=10 en=0 busy=1", a0, b0, en0, busy0);
    end
    run0 = 0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    mask0 = 4'b1111;
    run0  = 1;
    repeat (7) @(negedge clock);
    checks++;
    if ({a0, b0, en0} !== 3'b010) begin
      errors++; $display("FAIL rstmid_pre: got ab=%b%b en=%b exp ab=01 en=0", a0, b0, en0);
    end
    #1 reset_b = 0;
    #1;
    checks++;
    if ({a0, b0, en0, done0, busy0} !== 5'b00100) begin
      errors++; $display("FAIL rstmid_async: got %b exp 00100", {a0, b0, en0, done0, busy0});
    end
    @(negedge clock);
    reset_b = 1;
    @(negedge clock);
    checks++;
    if ({a0, b0, en0, busy0} !== 4'b0001) begin
      errors++; $display("FAIL rstmid_restart: got ab=%b%b en=%b busy=%b exp ab=00 en=0 busy=1", a0, b0, en0, busy0);
    end
    run0 = 0;
  endtask

  task automatic test_mask_zero;
    do_reset();
    mask0 = 4'b0000;
    run0  = 1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clock);
      checks++;
      if ({en0, busy0} !== 2'b10) begin
        errors++; $display("FAIL mask_zero t=%0d: got en=%b busy=%b exp en=1 busy=0", t, en0, busy0);
      end
    end
    mask0 = 4'b0001;
    @(negedge clock);
    checks++;
    if ({a0, b0, en0, busy0} !== 4'b0001) begin
      errors++; $display("FAIL mask_enable: got ab=%b%b en=%b busy=%b exp ab=00 en=0 busy=1", a0, b0, en0, busy0);
    end
    run0 = 0;
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_alt_mask();
    test_single_line();
    test_run_drop();
    test_reset_mid();
    test_mask_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
